// File: rtl/fp32_uart_pkg.sv
// Shared types and constants for the FP32 result UART transmitter.
// Contents: tx_state_t FSM encoding, word/byte widths, clks_per_bit() helper.
// Optional feature macro: FP32_RESULT_TX_PARITY_EN (PARITY state used only when defined).
package fp32_uart_pkg;

  localparam int unsigned FP32_W         = 32;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_t;

  function automatic int unsigned clks_per_bit(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Baud-period timer for the UART transmitter.
// Ports:
//   clk_i       system clock
//   rst_i       asynchronous active-high reset
//   restart_i   hold counter at zero (used while idle)
//   bit_done_o  high on the last cycle of each bit period
module uart_bit_timer #(
  parameter int unsigned ClksPerBit = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic restart_i,
  output logic bit_done_o
);

  localparam int unsigned CntW = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign bit_done_o = !restart_i && (cnt_q == CntW'(ClksPerBit - 1));

  // Wrapping on terminal count doubles as the reload at every state change,
  // since the FSM only changes state on bit_done.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart_i || bit_done_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fp32_result_uart_tx.sv
// Serialises one 32-bit FP32 result word as four UART frames (8N1, or 8E1 with parity).
// Ports:
//   clk           system clock
//   rst           asynchronous active-high reset
//   result_valid  result_data holds a word to transmit
//   result_data   FP32 word to send
//   result_ready  word accepted this cycle (high only while idle)
//   tx            serial line, idles high, driven from a flop
//   busy          word in flight (always the inverse of result_ready)
// Optional feature macro: FP32_RESULT_TX_PARITY_EN adds an even-parity bit per byte.
module fp32_result_uart_tx
  import fp32_uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned BAUD        = 115_200,
  parameter bit          MSB_FIRST   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              result_valid,
  input  logic [FP32_W-1:0] result_data,
  output logic              result_ready,
  output logic              tx,
  output logic              busy
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("fp32_result_uart_tx: CLK_FREQ_HZ/BAUD must be at least 2");
  end

  tx_state_t         state_q, state_d;
  logic [FP32_W-1:0] word_q, word_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic              tx_q, tx_d;
  logic              ready_q, ready_d;

  logic              bit_done;
  logic [1:0]        byte_sel;
  logic [BYTE_W-1:0] cur_byte;
  logic [2:0]        bit_nxt;

  uart_bit_timer #(
    .ClksPerBit(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .restart_i  (state_q == StIdle),
    .bit_done_o (bit_done)
  );

  // Byte k of the word in transmission order.
  assign byte_sel = MSB_FIRST ? (2'd3 - byte_idx_q) : byte_idx_q;
  assign cur_byte = word_q[{byte_sel, 3'b000} +: BYTE_W];
  assign bit_nxt  = bit_idx_q + 3'd1;

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    tx_d       = tx_q;
    ready_d    = ready_q;
    unique case (state_q)
      StIdle: begin
        if (result_valid && ready_q) begin
          word_d  = result_data;
          state_d = StStart;
          tx_d    = 1'b0;
          ready_d = 1'b0;
        end
      end
      StStart: begin
        if (bit_done) begin
          state_d   = StData;
          bit_idx_d = 3'd0;
          tx_d      = cur_byte[0];
        end
      end
      StData: begin
        if (bit_done) begin
          if (bit_idx_q == 3'd7) begin
`ifdef FP32_RESULT_TX_PARITY_EN
            state_d = StParity;
            tx_d    = ^cur_byte;
`else
            state_d = StStop;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_nxt;
            tx_d      = cur_byte[bit_nxt];
          end
        end
      end
`ifdef FP32_RESULT_TX_PARITY_EN
      StParity: begin
        if (bit_done) begin
          state_d = StStop;
          tx_d    = 1'b1;
        end
      end
`endif
      StStop: begin
        if (bit_done) begin
          if (byte_idx_q == 2'd3) begin
            state_d    = StIdle;
            byte_idx_d = 2'd0;
            ready_d    = 1'b1;
            tx_d       = 1'b1;
          end else begin
            // Next byte starts immediately, no idle gap within a word.
            state_d    = StStart;
            byte_idx_d = byte_idx_q + 2'd1;
            tx_d       = 1'b0;
          end
        end
      end
      default: begin
        state_d    = StIdle;
        byte_idx_d = 2'd0;
        ready_d    = 1'b1;
        tx_d       = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      word_q     <= '0;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= 2'd0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
    end
  end

  assign tx           = tx_q;
  assign result_ready = ready_q;
  assign busy         = !ready_q;

endmodule

// File: tb/tb_fp32_result_uart_tx.sv
// Directed self-checking bench for fp32_result_uart_tx (CLK_FREQ_HZ=400, BAUD=100 -> 4 clks/bit).
// Two instances: MSB_FIRST=1 (dut_m) and MSB_FIRST=0 (dut_l).
// Honours FP32_RESULT_TX_PARITY_EN to match the RTL build.
module tb_fp32_result_uart_tx;

  localparam int CPB = 4;
`ifdef FP32_RESULT_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int WORD_CYC = 4 * FB * CPB;
  localparam int LOG_N    = 400;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_m = 1'b0, valid_l = 1'b0;
  logic [31:0] data_m = '0, data_l = '0;
  logic        ready_m, ready_l, tx_m, tx_l, busy_m, busy_l;

  int checks = 0;
  int errors = 0;

  logic txlog  [LOG_N];
  logic rdylog [LOG_N];

  always #5 clk = ~clk;

  fp32_result_uart_tx #(
    .CLK_FREQ_HZ(400),
    .BAUD       (100),
    .MSB_FIRST  (1'b1)
  ) dut_m (
    .clk          (clk),
    .rst          (rst),
    .result_valid (valid_m),
    .result_data  (data_m),
    .result_ready (ready_m),
    .tx           (tx_m),
    .busy         (busy_m)
  );

  fp32_result_uart_tx #(
    .CLK_FREQ_HZ(400),
    .BAUD       (100),
    .MSB_FIRST  (1'b0)
  ) dut_l (
    .clk          (clk),
    .rst          (rst),
    .result_valid (valid_l),
    .result_data  (data_l),
    .result_ready (ready_l),
    .tx           (tx_l),
    .busy         (busy_l)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a word at the falling edge; returns 1 ns after the accepting rising edge.
  task automatic accept(input bit sel, input logic [31:0] w, input string tag);
    @(negedge clk);
    if (sel) begin
      valid_l = 1'b1;
      data_l  = w;
      chk({tag, "_ready"}, {31'd0, ready_l}, 32'd1);
    end else begin
      valid_m = 1'b1;
      data_m  = w;
      chk({tag, "_ready"}, {31'd0, ready_m}, 32'd1);
    end
    @(posedge clk);
    #1;
  endtask

  // Record tx/ready once per cycle; index k holds the value after the k-th edge.
  task automatic log_cycles(input bit sel, input int n);
    for (int i = 0; i < n; i++) begin
      txlog[i]  = sel ? tx_l : tx_m;
      rdylog[i] = sel ? ready_l : ready_m;
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int first_ready(input int from);
    for (int i = from; i < LOG_N; i++) begin
      if (rdylog[i] === 1'b1) return i;
    end
    return -1;
  endfunction

  // Decode four frames starting at log index base; exp lists bytes in line order.
  task automatic check_word(input string tag, input int base, input logic [31:0] exp);
    for (int f = 0; f < 4; f++) begin
      int          off;
      logic [7:0]  got;
      logic [7:0]  eb;
      off = base + f * FB * CPB;
      eb  = exp[8 * (3 - f) +: 8];
      for (int i = 0; i < 8; i++) got[i] = txlog[off + (1 + i) * CPB + 2];
      chk($sformatf("%s_b%0d_start", tag, f), {31'd0, txlog[off + 2]}, 32'd0);
      chk($sformatf("%s_b%0d_data", tag, f), {24'd0, got}, {24'd0, eb});
`ifdef FP32_RESULT_TX_PARITY_EN
      chk($sformatf("%s_b%0d_par", tag, f), {31'd0, txlog[off + 9 * CPB + 2]}, {31'd0, ^eb});
`endif
      chk($sformatf("%s_b%0d_stop", tag, f), {31'd0, txlog[off + (FB - 1) * CPB + 2]}, 32'd1);
    end
  endtask

  initial begin
    // 1: asynchronous reset, mid-cycle
    #3 rst = 1'b1;
    #1;
    chk("t1_tx_m", {31'd0, tx_m}, 32'd1);
    chk("t1_busy_m", {31'd0, busy_m}, 32'd0);
    chk("t1_ready_m", {31'd0, ready_m}, 32'd1);
    chk("t1_tx_l", {31'd0, tx_l}, 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("t1_idle_tx_%0d", i), {31'd0, tx_m}, 32'd1);
      chk($sformatf("t1_idle_rdy_%0d", i), {31'd0, ready_m}, 32'd1);
    end
    chk("t1_busy_idle", {31'd0, busy_m}, 32'd0);

    // 2: single word, MSB first
    accept(1'b0, 32'h3FC0_0000, "t2");
    valid_m = 1'b0;
    chk("t2_tx_fall", {31'd0, tx_m}, 32'd0);
    chk("t2_busy", {31'd0, busy_m}, 32'd1);
    log_cycles(1'b0, WORD_CYC + 10);
    chk("t2_ready_low", first_ready(0), WORD_CYC);
    check_word("t2", 0, 32'h3FC0_0000);
    chk("t2_idle_after", {31'd0, txlog[WORD_CYC + 5]}, 32'd1);

    // 3: LSB first
    accept(1'b1, 32'hC049_0FDB, "t3");
    valid_l = 1'b0;
    chk("t3_tx_fall", {31'd0, tx_l}, 32'd0);
    log_cycles(1'b1, WORD_CYC + 10);
    chk("t3_ready_low", first_ready(0), WORD_CYC);
    check_word("t3", 0, 32'hDB0F_49C0);

    // 4: valid held high; data changes while busy must be ignored
    accept(1'b0, 32'h3F80_0000, "t4");
    for (int i = 0; i < 2 * WORD_CYC + 20; i++) begin
      txlog[i]  = tx_m;
      rdylog[i] = ready_m;
      if (i == 20) data_m = 32'h4000_0000;
      if (i == WORD_CYC + 40) valid_m = 1'b0;
      @(posedge clk);
      #1;
    end
    chk("t4_rdy_before", {31'd0, rdylog[WORD_CYC - 1]}, 32'd0);
    chk("t4_rdy_return", {31'd0, rdylog[WORD_CYC]}, 32'd1);
    chk("t4_rdy_second", {31'd0, rdylog[WORD_CYC + 1]}, 32'd0);
    chk("t4_second_start", {31'd0, txlog[WORD_CYC + 1]}, 32'd0);
    chk("t4_ready_low2", first_ready(WORD_CYC + 1), 2 * WORD_CYC + 1);
    chk("t4_no_dup_rdy", {31'd0, rdylog[2 * WORD_CYC + 15]}, 32'd1);
    chk("t4_no_dup_tx", {31'd0, txlog[2 * WORD_CYC + 15]}, 32'd1);
    check_word("t4a", 0, 32'h3F80_0000);
    check_word("t4b", WORD_CYC + 1, 32'h4000_0000);

    // 5: reset in the middle of a word
    accept(1'b0, 32'h3FC0_0000, "t5");
    valid_m = 1'b0;
    repeat (50) @(posedge clk);
    #3;
    chk("t5_pre_rst_tx", {31'd0, tx_m}, 32'd0);
    rst = 1'b1;
    #1;
    chk("t5_rst_tx", {31'd0, tx_m}, 32'd1);
    chk("t5_rst_ready", {31'd0, ready_m}, 32'd1);
    chk("t5_rst_busy", {31'd0, busy_m}, 32'd0);
    @(negedge clk) rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("t5_no_resume_tx", {31'd0, tx_m}, 32'd1);
    chk("t5_no_resume_rdy", {31'd0, ready_m}, 32'd1);
    accept(1'b0, 32'h0000_0001, "t5b");
    valid_m = 1'b0;
    log_cycles(1'b0, WORD_CYC + 10);
    chk("t5_ready_low", first_ready(0), WORD_CYC);
    check_word("t5", 0, 32'h0000_0001);

`ifdef FP32_RESULT_TX_PARITY_EN
    // 6: parity bits 1,0,1,0 for bytes 01,03,07,00
    begin
      logic [3:0] par_exp;
      par_exp = 4'b0101;
      accept(1'b0, 32'h0103_0700, "t6");
      valid_m = 1'b0;
      log_cycles(1'b0, WORD_CYC + 10);
      chk("t6_ready_low", first_ready(0), 176);
      for (int f = 0; f < 4; f++) begin
        chk($sformatf("t6_par%0d", f), {31'd0, txlog[f * 44 + 9 * CPB + 2]}, {31'd0, par_exp[f]});
      end
      check_word("t6", 0, 32'h0103_0700);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
